// File: rtl/scan_chain_ctrl_if.sv
// Handshake and scan-port bundle between a test harness and scan_chain_ctrl.
// The controller takes the slave side; the harness and chain take the master side.
interface scan_chain_ctrl_if #(
    parameter int CHAIN_LEN = 8
);
    logic                 start;
    logic [CHAIN_LEN-1:0] pattern_in;
    logic                 So;
    logic                 NbarT;
    logic                 CE;
    logic                 Si;
    logic                 busy;
    logic                 done;
    logic [CHAIN_LEN-1:0] response_out;

    modport master (
        output start, pattern_in, So,
        input  NbarT, CE, Si, busy, done, response_out
    );

    modport slave (
        input  start, pattern_in, So,
        output NbarT, CE, Si, busy, done, response_out
    );
endinterface

// File: rtl/scan_chain_ctrl.sv
// Load -> capture -> unload sequencer for a single scan chain of dff cells.
// Every output is a flop computed from the next state, so none can glitch.
module scan_chain_ctrl #(
    parameter int   CHAIN_LEN = 8,
    parameter logic FILL_BIT  = 1'b0,
    localparam int  CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic             C,
    input  logic             global_reset,
    scan_chain_ctrl_if.slave bus
);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] SHIFT_IN  = 3'd1;
    localparam logic [2:0] CAPTURE   = 3'd2;
    localparam logic [2:0] SHIFT_OUT = 3'd3;
    localparam logic [2:0] DONE      = 3'd4;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);

    logic [2:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CHAIN_LEN-1:0] pat_q, pat_d;
    logic [CHAIN_LEN-1:0] shadow_q, shadow_d;
    logic [CHAIN_LEN-1:0] resp_q, resp_d;
    logic                 nbart_q, nbart_d;
    logic                 ce_q, ce_d;
    logic                 si_q, si_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pat_d    = pat_q;
        shadow_d = shadow_q;
        resp_d   = resp_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = SHIFT_IN;
                    cnt_d   = '0;
                    pat_d   = bus.pattern_in;
                end
            end
            SHIFT_IN: begin
                // MSB-first: the bit on Si is always pat_q[CHAIN_LEN-1]
                pat_d = pat_q << 1;
                if (cnt_q == LAST) begin
                    state_d = CAPTURE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            CAPTURE: begin
                state_d = SHIFT_OUT;
                cnt_d   = '0;
            end
            SHIFT_OUT: begin
                // first bit out is cell CHAIN_LEN-1, so it ends up at the MSB
                shadow_d = {shadow_q[CHAIN_LEN-2:0], bus.So};
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    resp_d  = shadow_d;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        nbart_d = 1'b0;
        ce_d    = 1'b0;
        si_d    = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        unique case (state_d)
            SHIFT_IN: begin
                nbart_d = 1'b1;
                ce_d    = 1'b1;
                si_d    = pat_d[CHAIN_LEN-1];
                busy_d  = 1'b1;
            end
            CAPTURE: begin
                ce_d   = 1'b1;
                si_d   = FILL_BIT;
                busy_d = 1'b1;
            end
            SHIFT_OUT: begin
                nbart_d = 1'b1;
                ce_d    = 1'b1;
                si_d    = FILL_BIT;
                busy_d  = 1'b1;
            end
            DONE: begin
                si_d   = FILL_BIT;
                done_d = 1'b1;
            end
            default: begin
                si_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge C) begin
        if (global_reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            pat_q    <= '0;
            shadow_q <= '0;
            resp_q   <= '0;
            nbart_q  <= 1'b0;
            ce_q     <= 1'b0;
            si_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pat_q    <= pat_d;
            shadow_q <= shadow_d;
            resp_q   <= resp_d;
            nbart_q  <= nbart_d;
            ce_q     <= ce_d;
            si_q     <= si_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.NbarT        = nbart_q;
    assign bus.CE           = ce_q;
    assign bus.Si           = si_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.response_out = resp_q;
endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl with a 4-cell chain whose capture function is selectable.
// A timeline model predicts every output cycle by cycle from the run phase.
module tb_scan_chain_ctrl;
    localparam int N = 4;
    localparam logic FILL = 1'b0;

    logic C = 1'b0;
    logic global_reset = 1'b1;
    int checks = 0;
    int failures = 0;
    int mode = 0;
    bit chk_en = 1'b0;

    scan_chain_ctrl_if #(.CHAIN_LEN(N)) bus ();

    scan_chain_ctrl #(.CHAIN_LEN(N), .FILL_BIT(FILL)) dut (
        .C(C),
        .global_reset(global_reset),
        .bus(bus)
    );

    always #5 C = ~C;

    // chain plant: mode 0 D=Q, 1 D=~Q, 2 cell2 D stuck at 1
    bit [N-1:0] chain = 4'b1010;
    assign bus.So = chain[N-1];

    function automatic bit [N-1:0] dvec(input bit [N-1:0] q, input int md);
        case (md)
            1: return ~q;
            2: return q | 4'b0100;
            default: return q;
        endcase
    endfunction

    always @(posedge C) begin
        if (bus.CE === 1'b1) begin
            if (bus.NbarT === 1'b1) chain <= {chain[N-2:0], bus.Si};
            else chain <= dvec(chain, mode);
        end
    end

    function automatic logic [N-1:0] golden(input logic [N-1:0] p, input int md);
        case (md)
            1: return ~p;
            2: return p | 4'b0100;
            default: return p;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // t = cycles since acceptance edge; 0 = idle
    int t = 0;
    logic [N-1:0] lat = '0;
    logic [N-1:0] exp_resp = '0;

    always @(posedge C) begin
        if (global_reset) begin
            t <= 0;
            lat <= '0;
            exp_resp <= '0;
        end else if (t == 0) begin
            if (bus.start) begin
                t <= 1;
                lat <= bus.pattern_in;
            end
        end else if (t == 2*N+2) begin
            t <= 0;
        end else begin
            t <= t + 1;
            if (t + 1 == 2*N+2) exp_resp <= golden(lat, mode);
        end
    end

    always @(negedge C) begin
        if (chk_en) begin
            automatic bit sh = (t >= 1 && t <= N) || (t >= N+2 && t <= 2*N+1);
            automatic bit act = (t >= 1 && t <= 2*N+1);
            chk("nbart", 32'(bus.NbarT), 32'(sh));
            chk("ce", 32'(bus.CE), 32'(act));
            chk("busy", 32'(bus.busy), 32'(act));
            chk("done", 32'(bus.done), 32'(t == 2*N+2));
            chk("resp", 32'(bus.response_out), 32'(exp_resp));
            if (act) begin
                if (t <= N) chk("si_load", 32'(bus.Si), 32'(lat[N-t]));
                else chk("si_fill", 32'(bus.Si), 32'(FILL));
            end
        end
    end

    task automatic run(input logic [N-1:0] p, input int md, input bit poke,
                       output int done_cyc, output int busy_cnt,
                       output int ndone, output logic [N-1:0] si_log);
        done_cyc = -1;
        busy_cnt = 0;
        ndone = 0;
        si_log = '0;
        mode = md;
        @(posedge C);
        #2;
        bus.start = 1'b1;
        bus.pattern_in = p;
        @(posedge C);
        #2;
        bus.start = 1'b0;
        bus.pattern_in = ~p;
        for (int k = 1; k <= 2*N+6; k++) begin
            @(negedge C);
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                ndone++;
                done_cyc = k;
            end
            if (k <= N) si_log[N-k] = bus.Si;
            if (poke && k == 4) bus.start = 1'b1;
            if (poke && k == 5) bus.start = 1'b0;
        end
    endtask

    int dc, bc, nd;
    logic [N-1:0] sl;
    int t4_n, t4_last;

    initial begin
        bus.start = 1'b0;
        bus.pattern_in = '0;
        repeat (2) @(posedge C);
        @(negedge C);
        chk("rst_nbart", 32'(bus.NbarT), 0);
        chk("rst_ce", 32'(bus.CE), 0);
        chk("rst_si", 32'(bus.Si), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_resp", 32'(bus.response_out), 0);
        global_reset = 1'b0;
        chk_en = 1'b1;

        // T2 identity capture
        run(4'b1011, 0, 1'b0, dc, bc, nd, sl);
        chk("t2_done_cyc", 32'(dc), 10);
        chk("t2_resp", 32'(bus.response_out), 32'(4'b1011));
        chk("t2_si_seq", 32'(sl), 32'(4'b1011));
        chk("t2_busy_cnt", 32'(bc), 9);
        chk("t2_ndone", 32'(nd), 1);

        // T1 reset for 2 cycles mid-unload
        mode = 0;
        @(posedge C);
        #2;
        bus.start = 1'b1;
        bus.pattern_in = 4'b0110;
        @(posedge C);
        #2;
        bus.start = 1'b0;
        repeat (7) @(negedge C);
        global_reset = 1'b1;
        repeat (2) @(posedge C);
        @(negedge C);
        chk("t1_nbart", 32'(bus.NbarT), 0);
        chk("t1_ce", 32'(bus.CE), 0);
        chk("t1_busy", 32'(bus.busy), 0);
        chk("t1_resp", 32'(bus.response_out), 0);
        global_reset = 1'b0;
        nd = 0;
        repeat (14) begin
            @(negedge C);
            if (bus.done) nd++;
        end
        chk("t1_no_done", 32'(nd), 0);

        // T3 inverting capture
        run(4'b0110, 1, 1'b0, dc, bc, nd, sl);
        chk("t3_resp", 32'(bus.response_out), 32'(4'b1001));
        chk("t3_done_cyc", 32'(dc), 10);

        // T4 start held high, pattern toggling
        mode = 0;
        t4_n = 0;
        t4_last = -1;
        for (int i = 0; i < 30; i++) begin
            @(posedge C);
            #2;
            bus.start = 1'b1;
            bus.pattern_in = i[0] ? 4'b1100 : 4'b0101;
            @(negedge C);
            if (bus.done) begin
                if (t4_last >= 0) chk("t4_gap", 32'(i - t4_last), 11);
                t4_last = i;
                t4_n++;
            end
        end
        bus.start = 1'b0;
        chk("t4_ndone", 32'(t4_n), 2);
        repeat (25) @(negedge C);
        chk("t4_idle", 32'(bus.busy), 0);

        // T5 start pulsed while busy
        run(4'b1110, 0, 1'b1, dc, bc, nd, sl);
        chk("t5_ndone", 32'(nd), 1);
        chk("t5_busy_cnt", 32'(bc), 9);
        chk("t5_resp", 32'(bus.response_out), 32'(4'b1110));

        // T6 stuck-at-1 on cell 2
        run(4'b0000, 2, 1'b0, dc, bc, nd, sl);
        chk("t6_resp", 32'(bus.response_out), 32'(4'b0100));

        repeat (3) @(negedge C);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
